instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams sequential words from a 1-cycle synchronous RAM
// into a small circular instruction buffer, with redirect (branch/PC write) flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_a,
    output logic        mem_rw,
    input  logic [31:0] mem_dout,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   committed;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: the head entry transfers on any rising edge where inst_valid and
    // inst_ready are both high; inst/inst_pc/inst_valid only change after a transfer,
    // a redirect or a reset.
    assign pop  = inst_valid & inst_ready;
    assign push = inflight & ~redirect;

    // Slots already spoken for after this edge: buffered plus returning, minus the pop.
    always_comb begin
        committed = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        issue     = ~redirect & (committed < (CW + 1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // Any pop this cycle is complete from the consumer's side; the rest is dropped.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= mem_dout;
            buf_pc[wr_ptr]   <= tag_pc;
        end
    end

    assign mem_a      = fetch_pc;
    assign mem_rw     = 1'b0;
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? buf_data[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cold start, backpressure, redirects,
// address wrap, async reset mid-stream and a randomly throttled consumer.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a, mem_dout;
    logic        mem_rw;
    logic [31:0] inst, inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] w_mem_a, w_mem_dout;
    logic        w_mem_rw;
    logic [31:0] w_inst, w_inst_pc;
    logic        w_inst_valid;
    logic        w_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int total;
    int bad;

    instruction_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .mem_a(mem_a), .mem_rw(mem_rw), .mem_dout(mem_dout),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .DEPTH(3)) dut_w (
        .clk(clk), .rst(rst), .mem_a(w_mem_a), .mem_rw(w_mem_rw), .mem_dout(w_mem_dout),
        .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid), .inst_ready(w_ready),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM model: word at address a reads as {8'hA0, a[23:0]}
    always @(posedge clk) begin
        mem_dout   <= {8'hA0, mem_a[23:0]};
        w_mem_dout <= {8'hA0, w_mem_a[23:0]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, {8'hA0, pc[23:0]});
    endtask

    logic [31:0] exp_pc;
    logic [31:0] zero32;

    initial begin
        total = 0;
        bad = 0;
        zero32 = 32'h0;
        rst = 1'b1;
        inst_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        w_ready = 1'b1;
        w_redirect = 1'b0;
        w_redirect_pc = 32'h0;

        // Reset state
        #2;
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_mem_a", mem_a, zero32);
        chk("rst_inst", inst, zero32);
        chk("rst_inst_pc", inst_pc, zero32);
        chk("rst_mem_rw", {31'b0, mem_rw}, 32'd0);
        chk("rst_w_mem_a", w_mem_a, 32'hFFFF_FFFE);
        tick;
        tick;
        rst = 1'b0;

        // Cold start: edge1 issues, edge2 delivers
        tick;
        chk("cold_e1_valid", {31'b0, inst_valid}, 32'd0);
        chk("cold_e1_mem_a", mem_a, 32'd1);
        tick;
        chk_head("cold_a0", 32'd0);
        chk_head_w_check(32'hFFFF_FFFE);
        tick;
        chk_head("cold_a1", 32'd1);
        chk_head_w_check(32'hFFFF_FFFF);
        tick;
        chk_head("cold_a2", 32'd2);
        chk_head_w_check(32'h0000_0000);
        tick;
        chk_head("cold_a3", 32'd3);

        // Backpressure: redirect to 0 while stalled, let the buffer fill
        inst_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick;
        redirect = 1'b0;
        chk("bp_flush_valid", {31'b0, inst_valid}, 32'd0);
        tick;
        tick;
        chk_head("bp_hold1", 32'd0);
        tick;
        chk_head("bp_hold2", 32'd0);
        tick;
        chk_head("bp_hold3", 32'd0);
        chk("bp_issue_stopped", mem_a, 32'd2);
        inst_ready = 1'b1;
        tick;
        chk_head("bp_drain_a1", 32'd1);

        // Redirect while A1 is consumed and A2 is in flight
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        chk("rd_e0_valid", {31'b0, inst_valid}, 32'd0);
        chk("rd_e0_mem_a", mem_a, 32'h40);
        tick;
        chk("rd_e1_valid", {31'b0, inst_valid}, 32'd0);
        chk("rd_e1_mem_a", mem_a, 32'h41);
        tick;
        chk_head("rd_e2", 32'h40);
        tick;
        chk_head("rd_e3", 32'h41);

        // Back-to-back redirects: last one wins
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick;
        redirect_pc = 32'h90;
        tick;
        redirect = 1'b0;
        chk("b2b_mem_a", mem_a, 32'h90);
        chk("b2b_valid", {31'b0, inst_valid}, 32'd0);
        tick;
        chk("b2b_e1_valid", {31'b0, inst_valid}, 32'd0);
        tick;
        chk_head("b2b_e2", 32'h90);
        tick;
        chk_head("b2b_e3", 32'h91);

        // Fill the buffer, then pulse async reset between edges
        inst_ready = 1'b0;
        tick;
        tick;
        chk_head("full_head", 32'h91);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_mem_a", mem_a, zero32);
        chk("arst_inst", inst, zero32);
        chk("arst_inst_pc", inst_pc, zero32);
        chk("arst_w_mem_a", w_mem_a, 32'hFFFF_FFFE);
        #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        tick;
        chk("arst_e1_valid", {31'b0, inst_valid}, 32'd0);
        tick;
        chk_head("arst_a0", 32'd0);
        chk_head_w_check(32'hFFFF_FFFE);
        tick;
        chk_head("arst_a1", 32'd1);

        // Randomly throttled consumer: pcs must stay strictly sequential
        exp_pc = 32'd1;
        for (int i = 0; i < 400; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            if (inst_valid && inst_ready) begin
                chk("rand_pc", inst_pc, exp_pc);
                chk("rand_inst", inst, {8'hA0, exp_pc[23:0]});
                exp_pc = exp_pc + 32'd1;
            end
            chk("rand_mem_rw", {31'b0, mem_rw}, 32'd0);
            tick;
        end
        chk("rand_progress", {31'b0, exp_pc > 32'd100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic chk_head_w_check(input logic [31:0] pc);
        chk("wrap_valid", {31'b0, w_inst_valid}, 32'd1);
        chk("wrap_pc", w_inst_pc, pc);
        chk("wrap_inst", w_inst, {8'hA0, pc[23:0]});
    endtask

endmodule
